// File: rtl/rgb_mixer_pkg.sv
// rgb_mixer_pkg: shared mode encodings and sequencer state type
package rgb_mixer_pkg;
  localparam logic [1:0] MODE_OFF = 2'd0;
  localparam logic [1:0] MODE_FOLLOW = 2'd1;
  localparam logic [1:0] MODE_RAMP = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;
  typedef enum logic [1:0] {WAIT, UPD0, UPD1, UPD2} seq_state_t;
endpackage

// File: rtl/step_prescaler.sv
// step_prescaler: free-running counter emitting a one-cycle step every STEP_DIV cycles
module step_prescaler #(
  parameter int STEP_DIV = 256
) (
  input  logic clk,
  input  logic reset,
  output logic step
);
  localparam int CW = $clog2(STEP_DIV);
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);
  logic [CW-1:0] cnt;
  // count 0..STEP_DIV-1 and wrap
  always_ff @(posedge clk) cnt <= (reset || cnt == LAST) ? '0 : cnt + CW'(1);
  assign step = !reset && cnt == LAST;
endmodule

// File: rtl/level_sequencer.sv
// level_sequencer: per-channel PWM level control (off/follow/ramp/breathe) over a shared round-robin datapath
module level_sequencer #(
  parameter int WIDTH = 8,
  parameter int STEP_DIV = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target0,
  input  logic [WIDTH-1:0] target1,
  input  logic [WIDTH-1:0] target2,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] level0,
  output logic [WIDTH-1:0] level1,
  output logic [WIDTH-1:0] level2,
  output logic             busy,
  output logic             step
);
  import rgb_mixer_pkg::*;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  seq_state_t state, state_nx;
  logic [1:0] mode_q;
  logic [WIDTH-1:0] tg [3];
  logic [WIDTH-1:0] lv [3];
  logic [WIDTH-1:0] env, env_nx, cur_t, cur_l, upd_val;
  logic [2*WIDTH-1:0] prod;
  logic [2:0] hit;
  logic dir;
  assign tg[0] = target0;
  assign tg[1] = target1;
  assign tg[2] = target2;
  assign level0 = lv[0];
  assign level1 = lv[1];
  assign level2 = lv[2];
  step_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (.clk(clk), .reset(reset), .step(step));
  // sequencer state register
  always_ff @(posedge clk) state <= reset ? WAIT : state_nx;
  // next state, busy flag and per-channel write strobes (only steps latched as RAMP/BREATHE write)
  always_comb begin
    state_nx = state == WAIT ? (step ? UPD0 : WAIT) : state == UPD0 ? UPD1 : state == UPD1 ? UPD2 : WAIT;
    busy = state != WAIT;
    hit = {state == UPD2, state == UPD1, state == UPD0} & {3{mode_q == MODE_RAMP || mode_q == MODE_BREATHE}};
  end
  // shared channel mux, +/-1 stepper and multiplier feeding the active channel
  always_comb begin
    cur_t = state == UPD0 ? tg[0] : state == UPD1 ? tg[1] : tg[2];
    cur_l = state == UPD0 ? lv[0] : state == UPD1 ? lv[1] : lv[2];
    prod = {{WIDTH{1'b0}}, cur_t} * {{WIDTH{1'b0}}, env};
    upd_val = mode_q == MODE_BREATHE ? prod[2*WIDTH-1:WIDTH] :
              cur_l < cur_t ? cur_l + ONE : cur_l > cur_t ? cur_l - ONE : cur_l;
    env_nx = dir ? env + ONE : env - ONE;
  end
  // mode is frozen for the whole step at its start
  always_ff @(posedge clk)
    if (reset) mode_q <= MODE_OFF;
    else if (state == WAIT && step) mode_q <= mode;
  // envelope moves once per breathing step, after all channels used the old value
  always_ff @(posedge clk)
    if (reset) begin
      env <= '0;
      dir <= 1'b1;
    end else if (state == UPD2 && mode_q == MODE_BREATHE) begin
      env <= env_nx;
      dir <= dir ? env_nx != '1 : env_nx == '0;
    end
  // live OFF/FOLLOW override every cycle; otherwise only the strobed channel changes
  always_ff @(posedge clk)
    for (int k = 0; k < 3; k++)
      lv[k] <= (reset || mode == MODE_OFF) ? '0 : mode == MODE_FOLLOW ? tg[k] : hit[k] ? upd_val : lv[k];
endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: directed self-checking bench for level_sequencer (WIDTH=8, STEP_DIV=4)
module tb_level_sequencer;
  import rgb_mixer_pkg::*;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] target0, target1, target2, level0, level1, level2;
  logic [1:0] mode;
  logic busy, step;
  int checks = 0;
  int errors = 0;
  level_sequencer #(.WIDTH(8), .STEP_DIV(4)) dut (
    .clk(clk), .reset(reset), .target0(target0), .target1(target1), .target2(target2),
    .mode(mode), .level0(level0), .level1(level1), .level2(level2), .busy(busy), .step(step)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_step;
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step && n < 8);
    chk("wait_step", {31'd0, step}, 1);
  endtask
  initial begin
    int ramp_up [4] = '{1, 2, 3, 3};
    int ramp_dn [2] = '{2, 1};
    int e;
    reset = 1'b1;
    mode = MODE_RAMP;
    target0 = 8'hFF;
    target1 = 8'hFF;
    target2 = 8'hFF;
    repeat (5) begin
      @(negedge clk);
      chk("rst_levels", {level0, level1, level2}, 0);
      chk("rst_flags", {busy, step}, 0);
    end
    reset = 1'b0;
    cyc(1); chk("c1_step", step, 0);
    cyc(1); chk("c2_step", step, 0);
    cyc(1); chk("c3_step", step, 1); chk("c3_busy", busy, 0);
    cyc(1); chk("c4_busy", busy, 1); chk("c4_level0", level0, 0);
    cyc(1); chk("c5_level0", level0, 1); chk("c5_level1", level1, 0);
    cyc(1); chk("c6_level1", level1, 1); chk("c6_busy", busy, 1);
    cyc(1); chk("c7_level2", level2, 1); chk("c7_busy", busy, 0); chk("c7_step", step, 1);
    mode = MODE_FOLLOW;
    target1 = 8'h00;
    cyc(1); chk("fol_level0", level0, 8'hFF); chk("fol_level1", level1, 8'h00);
    target1 = 8'h80;
    cyc(1); chk("fol_level1_80", level1, 8'h80);
    mode = MODE_OFF;
    cyc(1); chk("off_levels", {level0, level1, level2}, 0);
    mode = MODE_RAMP;
    target0 = 8'd3;
    target1 = 8'd0;
    target2 = 8'd0;
    foreach (ramp_up[i]) begin
      wait_step;
      cyc(2);
      chk("ramp_up_level0", level0, ramp_up[i]);
    end
    chk("ramp_busy", busy, 1);
    target0 = 8'd1;
    foreach (ramp_dn[i]) begin
      wait_step;
      cyc(2);
      chk("ramp_dn_level0", level0, ramp_dn[i]);
    end
    chk("ramp_level1", level1, 0);
    mode = MODE_BREATHE;
    target0 = 8'h80;
    target2 = 8'hFF;
    wait_step;
    for (int k = 0; k < 258; k++) begin
      e = k <= 255 ? k : 510 - k;
      cyc(2); chk("br_level0", level0, (128 * e) >> 8);
      cyc(2); chk("br_level2", level2, (255 * e) >> 8); chk("br_step", step, 1);
    end
    mode = MODE_RAMP;
    cyc(1);
    target2 = 8'h00;
    cyc(1); chk("mid_level0", level0, 127);
    cyc(2); chk("mid_t2_level2", level2, 251); chk("mid_step", step, 1);
    cyc(2); chk("mid_level0_b", level0, 128);
    mode = MODE_BREATHE;
    cyc(2); chk("mid_mode_level2", level2, 250); chk("mid_step_b", step, 1);
    target2 = 8'hFF;
    cyc(2); chk("env_hold_level0", level0, 126);
    cyc(2); chk("env_hold_level2", level2, 251);
    mode = MODE_RAMP;
    target1 = 8'h10;
    cyc(2); chk("pre_rst_busy", busy, 1); chk("pre_rst_level0", level0, 127);
    reset = 1'b1;
    cyc(1); chk("mrst_levels", {level0, level1, level2}, 0); chk("mrst_flags", {busy, step}, 0);
    reset = 1'b0;
    cyc(1); chk("r1_step", step, 0);
    cyc(1); chk("r2_step", step, 0);
    cyc(1); chk("r3_step", step, 1);
    cyc(2); chk("r5_level0", level0, 1); chk("r5_level1", level1, 0);
    cyc(1); chk("r6_level1", level1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/level_sequencer.md
# level_sequencer

Per-channel level controller between the three quadrature encoders and the three PWM generators of the RGB mixer. It turns encoder target values into PWM levels in one of four modes: off, direct follow, rate-limited ramp, or breathing envelope. Channels are updated round-robin through one shared step/multiply datapath, sequenced by a prescaled step FSM. It runs in the divided clock domain alongside the debouncers, encoders and PWMs.

## Interface
- WIDTH, 8, bit width of targets, levels and breathing envelope
- STEP_DIV, 256, clock cycles per sequencer step; legal range 4..65536

- clk  in  1  divided system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- target0, target1, target2  in  WIDTH  encoder values, one per channel
- mode  in  2  0 OFF, 1 FOLLOW, 2 RAMP, 3 BREATHE
- level0, level1, level2  out  WIDTH  PWM levels, registered
- busy  out  1  high while the FSM is in UPD0/UPD1/UPD2
- step  out  1  one-cycle pulse on the prescaler terminal count

## Operation
- Prescaler: counts 0..STEP_DIV-1, wraps. `step`=1 in the cycle count==STEP_DIV-1. Free-running in every mode.
- FSM states: WAIT, UPD0, UPD1, UPD2.
  - WAIT -> UPD0 when `step`=1. Otherwise stays in WAIT.
  - UPD0 -> UPD1 -> UPD2 -> WAIT, unconditionally, one cycle each.
- Mode latch: `mode` is sampled into `mode_q` on the WAIT->UPD0 transition and held through UPD2.
- Per-step channel update: in UPDi, channel i's target is sampled in that same cycle. The write to level_i takes effect at the end of UPDi.
- OFF (applies every cycle, not step-gated): all levels are 0 on the next cycle.
- FOLLOW (every cycle): level_i <= target_i with 1-cycle latency.
- RAMP (in UPDi only, mode_q==RAMP):
  - level_i < target_i: level_i+1
  - level_i > target_i: level_i-1
  - equal: hold
- BREATHE (in UPDi only, mode_q==BREATHE):
  - level_i <= (target_i * env) >> WIDTH.
  - A single WIDTH x WIDTH multiplier is shared across UPD0..2.
- Envelope `env` (WIDTH bits) plus direction bit `dir` (1 = up):
  - Advances only at the end of UPD2 with mode_q==BREATHE, after all three channels have used the old value.
  - Moving up: env+1. When env reaches 2^WIDTH-1, dir clears.
  - Moving down: env-1. When env reaches 0, dir sets.
  - The flip happens in the same cycle the extreme value is written.
  - Holds its value in all other modes.
- Mode precedence:
  - When the live `mode` is OFF or FOLLOW, that mode's every-cycle rule overrides any UPD write.
  - When the live `mode` is RAMP or BREATHE, levels change only in UPD cycles.
- Mode switches:
  - FOLLOW->RAMP continues from the current levels, with no jump.
  - Entering BREATHE updates levels at the next step using the held `env`.

## Timing
- Reset values:
  - level0..2 = 0, busy = 0, step = 0
  - FSM = WAIT, prescaler = 0
  - env = 0, dir = 1, mode_q = OFF
- Reset asserted mid-UPD aborts the step. No partial update survives.
- First `step` after reset release occurs at cycle STEP_DIV-1 (cycle 0 = first cycle with reset low).
- Step-to-output latency (RAMP/BREATHE): level0 changes 2 cycles after `step`, level1 after 3, level2 after 4.
- A target change during UPD0 is visible to channel 1 and channel 2 in that step, but not to channel 0.
- The largest RAMP traversal, 0 -> 2^WIDTH-1, takes (2^WIDTH-1) steps.
- `busy` is high for exactly 3 cycles per step. STEP_DIV>=4 guarantees no step arrives outside WAIT.

## Structure
- Shared package `rgb_mixer_pkg`:
  - mode constants MODE_OFF, MODE_FOLLOW, MODE_RAMP, MODE_BREATHE
  - FSM state typedef `seq_state_t`
- Sub-module `step_prescaler`: parameter STEP_DIV; ports clk, reset, step. The counter width is derived with $clog2(STEP_DIV).
- The channel mux, the ±1 comparator/adder and the multiplier are instantiated once each in the top module, shared across channels.

## Test plan
All scenarios use WIDTH=8, STEP_DIV=4.
- Reset: targets=0xFF, mode=RAMP, reset held 5 cycles -> levels 0, busy 0, step 0 throughout. First step pulse at cycle 3 after release; level0=1 at cycle 5.
- FOLLOW: mode=FOLLOW, target1 0x00->0x80 -> level1=0x80 exactly one cycle later. OFF then forces all levels to 0 one cycle after mode changes.
- RAMP: target0=3, level0=0 -> level0 reaches 1, 2, 3 on three consecutive steps, then holds at 3. Lowering target0 to 1 -> 2, then 1.
- BREATHE: target2=0xFF, env starting at 0 -> after 255 steps env=0xFF and dir=0. On the next step env=0xFE. level2 equals (0xFF*env_old)>>8 at each UPD2.
- Mid-step changes: change target2 during UPD0 -> the new value is used in the same step. Change mode RAMP->BREATHE during UPD1 -> the step stays RAMP (mode_q) and env does not advance.
- Reset mid-operation: assert reset during UPD1 of a RAMP step -> level1 is not updated, all state returns to reset values, and the prescaler restarts from 0.
